// File: rtl/mtrx_sub_scheduler.sv
// Round-robin scheduler sharing one external 1-cycle subtractor between two matrix requesters.
// Optional compile macro MTRX_SCHED_OVF_EN adds the per-lane signed overflow flag resp_ovf.
module mtrx_sub_scheduler #(
  parameter int LANE_W = 8,
  parameter int LANES  = 25
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [LANE_W*LANES-1:0]   req_a0,
  input  logic [LANE_W*LANES-1:0]   req_b0,
  input  logic [LANE_W*LANES-1:0]   req_a1,
  input  logic [LANE_W*LANES-1:0]   req_b1,
  output logic [1:0]                resp_valid,
  input  logic [1:0]                resp_ready,
  output logic [LANE_W*LANES-1:0]   resp_data,
  output logic [LANE_W*LANES-1:0]   sub_a,
  output logic [LANE_W*LANES-1:0]   sub_b,
  input  logic [LANE_W*LANES-1:0]   sub_c,
  output logic                      busy
`ifdef MTRX_SCHED_OVF_EN
  ,
  output logic                      resp_ovf
`endif
);

  localparam int MW = LANE_W * LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_ptr;
  logic            r_gnt;
  logic            w_gnt_vld;
  logic            w_gnt_idx;
  logic [MW-1:0]   r_sub_a;
  logic [MW-1:0]   r_sub_b;
  logic [MW-1:0]   r_resp_data;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_vld   = 1'b0;
    w_gnt_idx   = r_gnt;
    case (r_state)
      IDLE: begin
        // Gated by reset so req_ready stays low while reset is held.
        if (reset && (req_valid != 2'b00)) begin
          w_gnt_vld   = 1'b1;
          w_gnt_idx   = (req_valid == 2'b11) ? r_ptr : req_valid[1];
          w_state_nxt = ISSUE;
        end
      end
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    w_state_nxt = RESP;
      RESP: begin
        if (resp_ready[r_gnt]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_gnt       <= 1'b0;
      r_sub_a     <= '0;
      r_sub_b     <= '0;
      r_resp_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_vld) begin
        r_gnt   <= w_gnt_idx;
        r_ptr   <= ~w_gnt_idx;
        r_sub_a <= w_gnt_idx ? req_a1 : req_a0;
        r_sub_b <= w_gnt_idx ? req_b1 : req_b0;
      end
      if (r_state == WAIT) r_resp_data <= sub_c;
    end
  end

  assign req_ready  = w_gnt_vld ? (w_gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  assign resp_valid = (r_state == RESP) ? {r_gnt, ~r_gnt} : 2'b00;
  assign resp_data  = r_resp_data;
  assign sub_a      = r_sub_a;
  assign sub_b      = r_sub_b;
  assign busy       = (r_state != IDLE);

`ifdef MTRX_SCHED_OVF_EN
  logic              r_ovf;
  logic              w_ovf;
  logic [LANE_W-1:0] w_la;
  logic [LANE_W-1:0] w_lb;
  logic [LANE_W-1:0] w_ld;

  // Signed overflow of a-b: operand signs differ and the result sign differs from a.
  always_comb begin
    w_ovf = 1'b0;
    w_la  = '0;
    w_lb  = '0;
    w_ld  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_la = r_sub_a[i*LANE_W +: LANE_W];
      w_lb = r_sub_b[i*LANE_W +: LANE_W];
      w_ld = w_la - w_lb;
      if ((w_la[LANE_W-1] != w_lb[LANE_W-1]) && (w_ld[LANE_W-1] != w_la[LANE_W-1]))
        w_ovf = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_ovf <= 1'b0;
    else if (r_state == WAIT) r_ovf <= w_ovf;
  end

  assign resp_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_mtrx_sub_scheduler.sv
// Self-checking bench for mtrx_sub_scheduler: models the external subtractor and
// predicts grants, latency and results from the arbitration rules.
module tb_mtrx_sub_scheduler;
  localparam int LANE_W = 8;
  localparam int LANES  = 25;
  localparam int MW     = LANE_W * LANES;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [MW-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]    resp_valid;
  logic [1:0]    resp_ready;
  logic [MW-1:0] resp_data;
  logic [MW-1:0] sub_a, sub_b, sub_c;
  logic          busy;
`ifdef MTRX_SCHED_OVF_EN
  logic          resp_ovf;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  logic mdl_ptr  = 1'b0;

  always #5 clock = ~clock;

  mtrx_sub_scheduler #(.LANE_W(LANE_W), .LANES(LANES)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .sub_a      (sub_a),
    .sub_b      (sub_b),
    .sub_c      (sub_c),
    .busy       (busy)
`ifdef MTRX_SCHED_OVF_EN
    ,
    .resp_ovf   (resp_ovf)
`endif
  );

  function automatic logic [MW-1:0] sub_mat(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[i*LANE_W +: LANE_W] = a[i*LANE_W +: LANE_W] - b[i*LANE_W +: LANE_W];
    return r;
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = LANE_W'($urandom);
    return r;
  endfunction

  function automatic logic mdl_ovf(input logic [MW-1:0] a, input logic [MW-1:0] b);
    int sa, sb, sd;
    for (int i = 0; i < LANES; i++) begin
      sa = $signed(a[i*LANE_W +: LANE_W]);
      sb = $signed(b[i*LANE_W +: LANE_W]);
      sd = sa - sb;
      if (sd > 127 || sd < -128) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Shared subtractor: one registered cycle of latency.
  always @(posedge clock) sub_c <= sub_mat(sub_a, sub_b);

  // One complete operation; called in the IDLE cycle just after a negedge.
  task automatic do_op(input logic [1:0] rv, input logic [MW-1:0] a0, input logic [MW-1:0] b0,
                       input logic [MW-1:0] a1, input logic [MW-1:0] b1, input int stall,
                       output logic [MW-1:0] got, output logic got_ovf);
    int            g;
    logic [1:0]    oh;
    logic [MW-1:0] ea, eb, ed;
    logic          eovf;
    req_valid = rv; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
    #1;
    g       = (rv == 2'b11) ? int'(mdl_ptr) : int'(rv[1]);
    mdl_ptr = (g == 0);
    oh      = (g == 1) ? 2'b10 : 2'b01;
    ea      = (g == 1) ? a1 : a0;
    eb      = (g == 1) ? b1 : b0;
    ed      = sub_mat(ea, eb);
    eovf    = mdl_ovf(ea, eb);
    got_ovf = 1'b0;
    n_checks++;
    if (req_ready !== oh) begin n_fail++; $display("FAIL grant: req_ready=%b expected %b", req_ready, oh); end
    @(negedge clock);
    req_valid = 2'($urandom); req_a0 = rand_mat(); req_a1 = rand_mat(); req_b0 = rand_mat(); req_b1 = rand_mat();
    #1;
    n_checks++;
    if (req_ready !== 2'b00 || busy !== 1'b1 || resp_valid !== 2'b00) begin
      n_fail++; $display("FAIL issue_ctl: req_ready=%b busy=%b resp_valid=%b expected 00 1 00", req_ready, busy, resp_valid);
    end
    n_checks++;
    if (sub_a !== ea || sub_b !== eb) begin n_fail++; $display("FAIL issue_operands: sub_a=%h expected %h", sub_a, ea); end
    @(negedge clock); #1;
    n_checks++;
    if (resp_valid !== 2'b00 || busy !== 1'b1 || sub_a !== ea) begin
      n_fail++; $display("FAIL wait_state: resp_valid=%b busy=%b expected 00 1", resp_valid, busy);
    end
    @(negedge clock); #1;
    n_checks++;
    if (resp_valid !== oh) begin n_fail++; $display("FAIL resp_valid: got %b expected %b", resp_valid, oh); end
    n_checks++;
    if (resp_data !== ed) begin n_fail++; $display("FAIL resp_data: got %h expected %h", resp_data, ed); end
    got = resp_data;
`ifdef MTRX_SCHED_OVF_EN
    got_ovf = resp_ovf;
    n_checks++;
    if (resp_ovf !== eovf) begin n_fail++; $display("FAIL resp_ovf: got %b expected %b", resp_ovf, eovf); end
`endif
    for (int s = 0; s < stall; s++) begin
      resp_ready[g] = 1'b0; resp_ready[1-g] = 1'($urandom); req_valid = 2'($urandom);
      @(negedge clock); #1;
      n_checks++;
      if (resp_valid !== oh || resp_data !== ed || busy !== 1'b1 || req_ready !== 2'b00) begin
        n_fail++; $display("FAIL stall_hold: resp_valid=%b busy=%b req_ready=%b data_ok=%0d expected %b 1 00 1",
                            resp_valid, busy, req_ready, resp_data === ed, oh);
      end
    end
    resp_ready[g] = 1'b1; resp_ready[1-g] = 1'($urandom); req_valid = 2'($urandom);
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL handshake_no_grant: req_ready=%b expected 00", req_ready); end
    @(negedge clock);
    resp_ready = 2'b00;
    #1;
    n_checks++;
    if (resp_valid !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL resp_drop: resp_valid=%b busy=%b expected 00 0", resp_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 2'b11; resp_ready = 2'b00;
    req_a0 = rand_mat(); req_b0 = rand_mat(); req_a1 = rand_mat(); req_b1 = rand_mat();
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (req_ready !== 2'b00 || resp_valid !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: req_ready=%b resp_valid=%b busy=%b expected 00 00 0", req_ready, resp_valid, busy);
    end
    n_checks++;
    if (resp_data !== '0 || sub_a !== '0 || sub_b !== '0) begin
      n_fail++; $display("FAIL reset_data: resp_data=%h sub_a=%h sub_b=%h expected 0", resp_data, sub_a, sub_b);
    end
`ifdef MTRX_SCHED_OVF_EN
    n_checks++;
    if (resp_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", resp_ovf); end
`endif
    @(negedge clock);
    reset   = 1'b1;
    mdl_ptr = 1'b0;
  endtask

  task automatic test_alternate();
    logic [MW-1:0] got;
    logic          gov;
    for (int k = 0; k < 4; k++)
      do_op(2'b11, rand_mat(), rand_mat(), rand_mat(), rand_mat(), $urandom_range(0, 2), got, gov);
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    logic [MW-1:0] a, b, got;
    logic [7:0]    exp_lane;
    logic          gov;
    int            bad;
    for (int i = 0; i < LANES; i++) begin
      a[i*LANE_W +: LANE_W] = 8'(26 - i);
      b[i*LANE_W +: LANE_W] = 8'(i + 1);
    end
    do_op(2'b01, a, b, rand_mat(), rand_mat(), 0, got, gov);
    req_valid = 2'b00;
    bad = 0;
    for (int i = 0; i < LANES; i++) begin
      exp_lane = 8'(25 - 2 * i);
      if (got[i*LANE_W +: LANE_W] !== exp_lane) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL single_lanes: %0d lanes wrong, data=%h expected 0 wrong", bad, got); end
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] got;
    logic          gov;
    do_op(2'b10, rand_mat(), rand_mat(), rand_mat(), rand_mat(), 10, got, gov);
    req_valid = 2'b00;
  endtask

  task automatic test_random();
    logic [MW-1:0] got;
    logic          gov;
    logic [1:0]    rv;
    for (int k = 0; k < 10; k++) begin
      rv = 2'($urandom_range(1, 3));
      do_op(rv, rand_mat(), rand_mat(), rand_mat(), rand_mat(), $urandom_range(0, 3), got, gov);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_no_op();
    logic [MW-1:0] prev_a;
    prev_a    = sub_a;
    req_valid = 2'b01;
    #1;
    req_valid = 2'b00;
    @(negedge clock); #1;
    n_checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00 || sub_a !== prev_a) begin
      n_fail++; $display("FAIL withdrawn_request: busy=%b resp_valid=%b expected 0 00 with sub_a unchanged", busy, resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [MW-1:0] got;
    logic          gov;
    req_valid = 2'b01; req_a0 = rand_mat(); req_b0 = rand_mat();
    @(negedge clock);
    req_valid = 2'b00;
    @(negedge clock); #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (resp_valid !== 2'b00 || busy !== 1'b0 || sub_a !== '0) begin
      n_fail++; $display("FAIL reset_mid: resp_valid=%b busy=%b sub_a_zero=%0d expected 00 0 1", resp_valid, busy, sub_a === '0);
    end
    @(negedge clock);
    reset   = 1'b1;
    mdl_ptr = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (resp_valid !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_abort: resp_valid=%b busy=%b expected 00 0", resp_valid, busy);
    end
    do_op(2'b11, rand_mat(), rand_mat(), rand_mat(), rand_mat(), 1, got, gov);
    req_valid = 2'b00;
  endtask

`ifdef MTRX_SCHED_OVF_EN
  task automatic test_ovf();
    logic [MW-1:0] a, b, got;
    logic          gov;
    a = '0; b = '0;
    a[7*LANE_W +: LANE_W] = 8'd127;
    b[7*LANE_W +: LANE_W] = 8'hFF;
    do_op(2'b01, a, b, rand_mat(), rand_mat(), 0, got, gov);
    n_checks++;
    if (gov !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", gov); end
    for (int i = 0; i < LANES; i++) begin
      a[i*LANE_W +: LANE_W] = 8'd5;
      b[i*LANE_W +: LANE_W] = 8'd3;
    end
    do_op(2'b10, rand_mat(), rand_mat(), a, b, 0, got, gov);
    req_valid = 2'b00;
    n_checks++;
    if (gov !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", gov); end
  endtask
`endif

  initial begin
    test_reset();
    test_alternate();
    test_single();
    test_backpressure();
    test_no_op();
    test_random();
    test_reset_mid();
`ifdef MTRX_SCHED_OVF_EN
    test_ovf();
`endif
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mtrx_sub_scheduler.md
MTRX_SUB_SCHEDULER -- requirements
Module: mtrx_sub_scheduler

Interface
REQ-001 SHALL have parameter LANE_W, default 8: bits per signed matrix element.
REQ-002 SHALL have parameter LANES, default 25: elements per packed matrix (5x5); the matrix width is MW = LANE_W*LANES (200).
REQ-003 SHALL have port clock, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 2: bit k is requester k's operation request.
REQ-006 SHALL have port req_ready, output, 2: bit k high means requester k's request is accepted this cycle.
REQ-007 SHALL have ports req_a0, req_b0, req_a1, req_b1, input, MW each: the packed operands of requester 0 and requester 1.
REQ-008 SHALL have port resp_valid, output, 2: bit k high means resp_data holds requester k's result.
REQ-009 SHALL have port resp_ready, input, 2: bit k is requester k's result acceptance.
REQ-010 SHALL have port resp_data, output, MW: the result matrix.
REQ-011 SHALL have ports sub_a and sub_b, output, MW each: operands driven to the shared subtractor, which has a 1-cycle registered latency.
REQ-012 SHALL have port sub_c, input, MW: the shared subtractor's result.
REQ-013 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-015 In IDLE with any req_valid bit high, SHALL grant exactly one requester, pulse its req_ready for that cycle only, and move to ISSUE.
REQ-016 Arbitration SHALL be round-robin: the pointer starts at requester 0 and, on a grant, moves to the other requester; with a single request pending, that request wins regardless of the pointer.
REQ-017 On a grant, SHALL register that requester's a/b onto sub_a/sub_b and hold them stable until the next grant.
REQ-018 ISSUE SHALL last 1 cycle, then move to WAIT; the subtractor samples its inputs at the end of ISSUE.
REQ-019 WAIT SHALL last 1 cycle, capture sub_c into resp_data at the end of WAIT, then move to RESP.
REQ-020 In RESP, SHALL drive resp_valid[granted]=1 and hold resp_data stable until resp_ready[granted]=1.
REQ-021 On that handshake, SHALL move to IDLE; resp_valid SHALL drop in the next cycle.
REQ-022 resp_ready on the non-granted bit SHALL be ignored.
REQ-023 Grant-to-resp_valid latency SHALL be exactly 3 cycles: grant edge T0, valid from the cycle after T2.
REQ-024 req_ready SHALL be 0 in every state except the IDLE grant cycle, so at most one operation is in flight.
REQ-025 A new grant SHALL NOT occur in the same cycle as a response handshake; the earliest next grant is the following IDLE cycle.
REQ-026 req_valid deasserted before grant SHALL produce no operation; req_valid changes after grant SHALL have no effect.
REQ-027 resp_data SHALL be exactly sub_c as captured; the block performs no arithmetic except as stated in REQ-032.

Reset
REQ-028 While reset is low, the FSM SHALL be in IDLE, the round-robin pointer SHALL be 0, and req_ready, resp_valid, busy, resp_data, sub_a and sub_b SHALL all be 0.
REQ-029 A reset asserted mid-operation (ISSUE, WAIT or RESP) SHALL abort it immediately, with no response delivered.
REQ-030 After reset is released, the first grant SHALL occur on the first rising edge with req_valid nonzero.

Configuration
REQ-031 Macro MTRX_SCHED_OVF_EN SHALL be the only compile option.
REQ-032 When MTRX_SCHED_OVF_EN is defined, SHALL add output resp_ovf (1 bit), valid with resp_valid.
REQ-033 resp_ovf SHALL be high if any lane of a-b, taken as signed LANE_W values, overflows: the operands differ in sign and the result sign differs from a's sign.
REQ-034 resp_ovf SHALL be computed from the registered sub_a/sub_b and registered alongside resp_data.
REQ-035 resp_ovf SHALL reset to 0.
REQ-036 When MTRX_SCHED_OVF_EN is undefined, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 Single request: req_valid=01, a lanes 26..2, b lanes 1..25 -> req_ready=01 for one cycle, resp_valid=01 three cycles later, resp_data lanes 25,23,...,1,255,253,...,233.
REQ-038 Simultaneous request: req_valid=11 held from reset -> grants alternate 0,1,0,1; each resp_valid bit matches the granted requester.
REQ-039 Backpressure: resp_ready=0 for 10 cycles in RESP -> resp_valid and resp_data held constant, busy=1, req_ready=00 throughout.
REQ-040 Reset mid-operation: reset low during WAIT -> next cycle resp_valid=00, busy=0, sub_a=0; after release a new request completes normally.
REQ-041 Overflow (MTRX_SCHED_OVF_EN defined): lane a=127, b=-1 -> resp_ovf=1; a=5, b=3 in all lanes -> resp_ovf=0.
REQ-042 Overflow feature off (MTRX_SCHED_OVF_EN undefined): the REQ-037 stimulus -> identical cycle timing and data.
